// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the parametrised single-clock FIFO.
//   DEF_WIDTH / DEF_DEPTH : default data width and entry count
//   addr_w()              : address width for a given depth
//   fifo_status_t         : packed status flags as registered by the FIFO
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Address bits needed to index 'depth' entries (never below one bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
    logic ovf;
    logic udf;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Simple dual-port storage array: one synchronous write port and one read
// port. REG_RD=1 gives a registered read (rdata updates on an edge with re=1,
// cleared by rst); REG_RD=0 gives a combinational read of mem[raddr].
// Array contents are never reset.
//   clk, rst           : clock, synchronous active-high reset (read reg only)
//   we, waddr, wdata   : write port
//   re, raddr, rdata   : read port
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter bit REG_RD = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       re,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  generate
    if (REG_RD) begin : g_reg_rd
      logic [WIDTH-1:0] rdata_q;
      logic [WIDTH-1:0] rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
      end

      always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end else begin : g_comb_rd
      // Head word is presented directly; rst/re have no role here.
      logic unused_rd;
      assign unused_rd = rst ^ re;
      assign rdata     = mem_q[raddr];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with occupancy count, almost-full / almost-empty
// thresholds, sticky overflow / underflow flags and a synchronous flush.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word fall-through
// (head word visible on RDATA while REMPTY=0); otherwise RDATA is registered
// and valid the cycle after an accepted RINC.
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   CLR             : synchronous flush (RDATA keeps its value)
//   WINC, WDATA     : write request / data
//   WFULL, WALMOST_FULL, WOVF : full, COUNT>=AF_THRESH, sticky overflow
//   RINC, RDATA     : read request / data
//   REMPTY, RALMOST_EMPTY, RUDF : empty, COUNT<=AE_THRESH, sticky underflow
//   COUNT           : occupancy 0..DEPTH
//
// Handshake: a word is written on a rising edge where WINC=1 and WFULL=0, and
// popped on a rising edge where RINC=1 and REMPTY=0. WFULL/REMPTY act as the
// ready indications and are sampled from registered state; a request made
// while not ready is dropped and recorded in WOVF/RUDF until RST or CLR.
// -----------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     WINC,
  input  logic [WIDTH-1:0]         WDATA,
  output logic                     WFULL,
  output logic                     WALMOST_FULL,
  output logic                     WOVF,
  input  logic                     RINC,
  output logic [WIDTH-1:0]         RDATA,
  output logic                     REMPTY,
  output logic                     RALMOST_EMPTY,
  output logic                     RUDF,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int ADDR = addr_w(DEPTH);
  localparam int CW   = ADDR + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  localparam fifo_status_t STATUS_RST = '{
    full: 1'b0, almost_full: 1'b0, empty: 1'b1,
    almost_empty: 1'b1, ovf: 1'b0, udf: 1'b0
  };

  logic [ADDR:0]  wptr_q, wptr_d;
  logic [ADDR:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  fifo_status_t   status_q, status_d;

  logic wr_acc, rd_acc;
  logic mem_we, mem_re;

  // Acceptance uses the registered flags, so full+WINC+RINC pops but does
  // not push, and empty+WINC+RINC pushes but does not pop.
  assign wr_acc = WINC && !status_q.full;
  assign rd_acc = RINC && !status_q.empty;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    status_d = status_q;
    mem_we   = 1'b0;
    mem_re   = 1'b0;

    if (CLR) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      status_d = STATUS_RST;
    end else begin
      if (wr_acc) begin
        mem_we = !RST;
        wptr_d = wptr_q + 1'b1;
      end
      if (rd_acc) begin
        mem_re = !RST;
        rptr_d = rptr_q + 1'b1;
      end

      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      // Level flags follow the next occupancy so they change with COUNT.
      status_d.full         = (count_d == DEPTH_C);
      status_d.almost_full  = (count_d >= AF_C);
      status_d.empty        = (count_d == '0);
      status_d.almost_empty = (count_d <= AE_C);
      status_d.ovf          = status_q.ovf | (WINC & status_q.full);
      status_d.udf          = status_q.udf | (RINC & status_q.empty);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      status_q <= STATUS_RST;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  sync_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .REG_RD (!FWFT)
  ) u_mem (
    .clk   (CLK),
    .rst   (RST),
    .we    (mem_we),
    .waddr (wptr_q[ADDR-1:0]),
    .wdata (WDATA),
    .re    (mem_re),
    .raddr (rptr_q[ADDR-1:0]),
    .rdata (RDATA)
  );

  assign COUNT         = count_q;
  assign WFULL         = status_q.full;
  assign WALMOST_FULL  = status_q.almost_full;
  assign REMPTY        = status_q.empty;
  assign RALMOST_EMPTY = status_q.almost_empty;
  assign WOVF          = status_q.ovf;
  assign RUDF          = status_q.udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16). A queue-based
// reference model tracks contents, sticky flags and the expected RDATA; every
// output is compared at the falling edge after each clock.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, clr, winc, rinc;
  logic [WIDTH-1:0] wdata, rdata;
  logic             wfull, walmost_full, wovf;
  logic             rempty, ralmost_empty, rudf;
  logic [4:0]       count;

  sync_fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .CLR           (clr),
    .WINC          (winc),
    .WDATA         (wdata),
    .WFULL         (wfull),
    .WALMOST_FULL  (walmost_full),
    .WOVF          (wovf),
    .RINC          (rinc),
    .RDATA         (rdata),
    .REMPTY        (rempty),
    .RALMOST_EMPTY (ralmost_empty),
    .RUDF          (rudf),
    .COUNT         (count)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf;
  logic             exp_udf;
  logic [WIDTH-1:0] exp_rdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Applies the FIFO rules to the model for one clock edge.
  task automatic model_step(input bit r, input bit c, input bit wi,
                            input logic [WIDTH-1:0] wd, input bit ri);
    bit was_full, was_empty;
    if (r) begin
      exp_q.delete();
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
      exp_rdata = '0;
    end else if (c) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (wi && was_full)  exp_ovf = 1'b1;
      if (ri && was_empty) exp_udf = 1'b1;
      if (ri && !was_empty) exp_rdata = exp_q.pop_front();
      if (wi && !was_full)  exp_q.push_back(wd);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check_eq("count",         32'(count),         32'(sz));
    check_eq("rempty",        32'(rempty),        32'(sz == 0));
    check_eq("wfull",         32'(wfull),         32'(sz == DEPTH));
    check_eq("walmost_full",  32'(walmost_full),  32'(sz >= AF));
    check_eq("ralmost_empty", 32'(ralmost_empty), 32'(sz <= AE));
    check_eq("wovf",          32'(wovf),          32'(exp_ovf));
    check_eq("rudf",          32'(rudf),          32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
    if (sz != 0) check_eq("rdata_head", 32'(rdata), 32'(exp_q[0]));
`else
    check_eq("rdata", 32'(rdata), 32'(exp_rdata));
`endif
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives one cycle and checks after the edge.
  task automatic cycle(input bit r, input bit c, input bit wi,
                       input logic [WIDTH-1:0] wd, input bit ri);
    rst = r; clr = c; winc = wi; wdata = wd; rinc = ri;
    @(posedge clk);
    model_step(r, c, wi, wd, ri);
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; winc = 1'b0; rinc = 1'b0;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    exp_ovf = 1'b0; exp_udf = 1'b0; exp_rdata = '0;
    @(negedge clk);

    // Reset then idle.
    cycle(1, 0, 0, 8'h00, 0);
    cycle(1, 0, 0, 8'h00, 0);
    check_eq("rst_rdata", 32'(rdata), 32'h0);
    cycle(0, 0, 0, 8'h00, 0);

    // Fill 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, 8'(i), 0);
      if (i == 12) check_eq("af_below", 32'(walmost_full), 32'h0);
      if (i == 13) check_eq("af_rise",  32'(walmost_full), 32'h1);
    end
    check_eq("fill_full", 32'(wfull), 32'h1);

    // 17th write rejected.
    cycle(0, 0, 1, 8'hAA, 0);
    check_eq("ovf_set",    32'(wovf),  32'h1);
    check_eq("ovf_count",  32'(count), 32'd16);

    // Drain.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 0, 8'h00, 1);
`ifndef SYNC_FIFO_FWFT_EN
      check_eq("drain_data", 32'(rdata), 32'(i));
`endif
    end
    check_eq("drain_empty", 32'(rempty), 32'h1);

    // Extra read while empty.
    cycle(0, 0, 0, 8'h00, 1);
    check_eq("udf_set",   32'(rudf),  32'h1);
    check_eq("udf_count", 32'(count), 32'd0);

    // Empty with write+read together.
    cycle(0, 0, 1, 8'h11, 1);
    check_eq("empty_both_count", 32'(count), 32'd1);

    // Flush, then hold at COUNT=5 with simultaneous traffic.
    cycle(0, 1, 0, 8'h00, 0);
    for (int k = 0; k < 32 && exp_q.size() < 5; k++)
      cycle(0, 0, 1, 8'($urandom_range(0, 255)), 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 1, 8'($urandom_range(0, 255)), 1);
      check_eq("both_count5", 32'(count), 32'd5);
    end

    // Full with write+read together.
    for (int k = 0; k < 32 && exp_q.size() < DEPTH; k++)
      cycle(0, 0, 1, 8'($urandom_range(0, 255)), 0);
    cycle(0, 0, 1, 8'hEE, 1);
    check_eq("full_both_count", 32'(count), 32'd15);
    check_eq("full_both_ovf",   32'(wovf),  32'h1);

    // Random traffic across pointer wrap, write-biased.
    cycle(0, 1, 0, 8'h00, 0);
    for (int k = 0; k < 40; k++)
      cycle(0, 0, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 1) == 1));

    // Settle at COUNT=7, then flush.
    for (int k = 0; k < 40 && exp_q.size() != 7; k++) begin
      if (exp_q.size() < 7) cycle(0, 0, 1, 8'($urandom_range(0, 255)), 0);
      else                  cycle(0, 0, 0, 8'h00, 1);
    end
    check_eq("pre_clr_count", 32'(count), 32'd7);
    cycle(0, 1, 1, 8'h77, 1);
    check_eq("clr_count",  32'(count),  32'd0);
    check_eq("clr_rempty", 32'(rempty), 32'h1);
    check_eq("clr_wovf",   32'(wovf),   32'h0);
    check_eq("clr_rudf",   32'(rudf),   32'h0);

    // Post-flush write reads back.
    cycle(0, 0, 1, 8'h5A, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check_eq("fwft_5a", 32'(rdata), 32'h5A);
    cycle(0, 0, 0, 8'h00, 1);
    check_eq("fwft_pop_empty", 32'(rempty), 32'h1);
    // First-word fall-through from empty.
    cycle(0, 0, 1, 8'h3C, 0);
    check_eq("fwft_3c_rempty", 32'(rempty), 32'h0);
    check_eq("fwft_3c_rdata",  32'(rdata),  32'h3C);
    cycle(0, 0, 0, 8'h00, 1);
    check_eq("fwft_3c_pop", 32'(rempty), 32'h1);
`else
    cycle(0, 0, 0, 8'h00, 1);
    check_eq("readback_5a", 32'(rdata), 32'h5A);
`endif

    // Long random run with occasional flush / reset.
    for (int k = 0; k < 300; k++)
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 1) == 1), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 1) == 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
